// File: rtl/jt12_op_mixer.sv
// -----------------------------------------------------------------------------
// jt12_op_mixer
//
// Consumes the 24-slot TDM stream of 9-bit signed operator results. For each
// channel it sums the carrier operators selected by the channel's algorithm,
// saturates the channel sum, applies L/R panning, and mixes all channels into
// one stereo sample per frame.
//
// Optional feature: define JT12_MIXER_DAC_EN to add dac_en/dac_data. With
// dac_en high at the last slot (ch5 S4), ch5 is replaced by dac_data.
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous reset, active low
//   clk_en        in   slot advance enable; every state update is gated by it
//   zero          in   current slot is slot 0 (ch0 S1)
//   op_result     in   operator output for the current slot, signed CH_W
//   alg           in   algorithm of the current slot's channel
//   pan           in   {left,right} enable of the current slot's channel
//   dac_en        in   (JT12_MIXER_DAC_EN) replace ch5 with dac_data
//   dac_data      in   (JT12_MIXER_DAC_EN) signed DAC sample
//   left, right   out  mixed stereo sample, signed OUT_W
//   sample_valid  out  strobe
//
// Output handshake: sample_valid is a one-clock strobe with no back-pressure.
// It rises for the single clock that follows the clk_en edge that processed
// the last slot of a complete, synchronised frame; left/right change only on
// that same edge and hold their value until the next valid frame.
// -----------------------------------------------------------------------------
module jt12_op_mixer #(
  parameter int NUM_CH = 6,
  parameter int CH_W   = 9,
  parameter int OUT_W  = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic                    zero,
  input  logic signed [CH_W-1:0]  op_result,
  input  logic [2:0]              alg,
  input  logic [1:0]              pan,
`ifdef JT12_MIXER_DAC_EN
  input  logic                    dac_en,
  input  logic signed [CH_W-1:0]  dac_data,
`endif
  output logic signed [OUT_W-1:0] left,
  output logic signed [OUT_W-1:0] right,
  output logic                    sample_valid
);

  localparam int NUM_SLOT = 4 * NUM_CH;
  localparam int SLOT_W   = $clog2(NUM_SLOT);
  localparam int CHI_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // Partial holds up to three operators; the S4 sum holds up to four.
  localparam int PART_W   = CH_W + 2;
  localparam int SUM_W    = CH_W + 3;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOT - 1);
  localparam logic [SLOT_W-1:0] S4_FIRST  = SLOT_W'(3 * NUM_CH);
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (CH_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SLOT_W-1:0]        cnt;       // slot expected for the current input
  logic                     synced;    // a zero has been seen since reset
  logic                     frame_ok;  // current frame started cleanly
  logic signed [PART_W-1:0] partial [NUM_CH];
  logic signed [OUT_W-1:0]  sum_l;
  logic signed [OUT_W-1:0]  sum_r;

  // ---------------------------------------------------------------------------
  // Slot decode: zero overrides the counter so the current slot is slot 0.
  // ---------------------------------------------------------------------------
  logic [SLOT_W-1:0] slot;
  logic [1:0]        grp;   // 0:S1 1:S3 2:S2 3:S4
  logic [CHI_W-1:0]  ch;
  logic              resync;

  assign slot   = zero ? '0 : cnt;
  assign resync = clk_en && zero && (cnt != '0);

  always_comb begin
    grp = 2'd3;
    ch  = '0;
    if (slot < SLOT_W'(NUM_CH)) begin
      grp = 2'd0;
      ch  = CHI_W'(slot);
    end else if (slot < SLOT_W'(2 * NUM_CH)) begin
      grp = 2'd1;
      ch  = CHI_W'(slot - SLOT_W'(NUM_CH));
    end else if (slot < SLOT_W'(3 * NUM_CH)) begin
      grp = 2'd2;
      ch  = CHI_W'(slot - SLOT_W'(2 * NUM_CH));
    end else begin
      grp = 2'd3;
      ch  = CHI_W'(slot - SLOT_W'(3 * NUM_CH));
    end
  end

  // ---------------------------------------------------------------------------
  // Carrier decode for the operator in the current slot.
  //   S1: alg7          S3: alg5-7          S2: alg4-7          S4: always
  // ---------------------------------------------------------------------------
  logic carrier;

  always_comb begin
    carrier = 1'b0;
    case (grp)
      2'd0:    carrier = (alg == 3'd7);
      2'd1:    carrier = (alg >= 3'd5);
      2'd2:    carrier = (alg >= 3'd4);
      default: carrier = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Partial accumulation and channel saturation
  // ---------------------------------------------------------------------------
  logic signed [PART_W-1:0] part_cur;
  logic signed [PART_W-1:0] op_p;
  logic signed [PART_W-1:0] part_next;
  logic signed [SUM_W-1:0]  op_x;
  logic signed [SUM_W-1:0]  part_x;
  logic signed [SUM_W-1:0]  s4_sum;
  logic signed [CH_W-1:0]   chan;

  assign part_cur = partial[ch];
  assign op_p     = {{(PART_W - CH_W){op_result[CH_W-1]}}, op_result};
  assign op_x     = {{(SUM_W - CH_W){op_result[CH_W-1]}}, op_result};
  assign part_x   = {{(SUM_W - PART_W){part_cur[PART_W-1]}}, part_cur};
  assign s4_sum   = part_x + op_x;

  always_comb begin
    part_next = part_cur;
    if (grp == 2'd0) begin
      // First operator of the channel in the frame: load, never accumulate.
      part_next = carrier ? op_p : '0;
    end else if (carrier) begin
      part_next = part_cur + op_p;
    end
  end

  always_comb begin
    if (s4_sum > SAT_MAX) begin
      chan = SAT_MAX[CH_W-1:0];
    end else if (s4_sum < SAT_MIN) begin
      chan = SAT_MIN[CH_W-1:0];
    end else begin
      chan = s4_sum[CH_W-1:0];
    end
`ifdef JT12_MIXER_DAC_EN
    // The DAC takes ch5's place in the mix; its pan setting still applies.
    if (dac_en && (slot == LAST_SLOT)) begin
      chan = dac_data;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Stereo mixing. The first S4 slot restarts the running sums.
  // ---------------------------------------------------------------------------
  logic signed [OUT_W-1:0] chan_x;
  logic signed [OUT_W-1:0] l_add;
  logic signed [OUT_W-1:0] r_add;
  logic signed [OUT_W-1:0] sum_l_next;
  logic signed [OUT_W-1:0] sum_r_next;

  assign chan_x = {{(OUT_W - CH_W){chan[CH_W-1]}}, chan};
  assign l_add  = pan[1] ? chan_x : '0;
  assign r_add  = pan[0] ? chan_x : '0;

  always_comb begin
    if (slot == S4_FIRST) begin
      sum_l_next = l_add;
      sum_r_next = r_add;
    end else begin
      sum_l_next = sum_l + l_add;
      sum_r_next = sum_r + r_add;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      synced       <= 1'b0;
      frame_ok     <= 1'b0;
      sum_l        <= '0;
      sum_r        <= '0;
      left         <= '0;
      right        <= '0;
      sample_valid <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        partial[i] <= '0;
      end
    end else begin
      sample_valid <= 1'b0;
      if (clk_en) begin
        cnt <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;

        if (zero) begin
          synced <= 1'b1;
        end

        // A zero arriving mid-frame abandons everything gathered so far;
        // the slot-0 load below still applies on top of the clear.
        if (resync) begin
          for (int i = 0; i < NUM_CH; i++) begin
            partial[i] <= '0;
          end
          sum_l <= '0;
          sum_r <= '0;
        end

        if (grp != 2'd3) begin
          partial[ch] <= part_next;
        end

        // A frame counts only if it began at an explicit zero or at a
        // wrap that follows an earlier zero.
        if (slot == '0) begin
          frame_ok <= zero | synced;
        end

        if (grp == 2'd3) begin
          sum_l <= sum_l_next;
          sum_r <= sum_r_next;
        end

        if ((slot == LAST_SLOT) && frame_ok) begin
          left         <= sum_l_next;
          right        <= sum_r_next;
          sample_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jt12_op_mixer.sv
// -----------------------------------------------------------------------------
// tb_jt12_op_mixer
//
// Table of frame vectors with hand-computed stereo results, applied with random
// clk_en gaps. Expected samples are queued when a frame is driven and popped
// when sample_valid strobes. Hand-written sequences cover resync, mid-frame
// reset and unsynchronised frames.
// -----------------------------------------------------------------------------
module tb_jt12_op_mixer;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              clk_en;
  logic              zero;
  logic signed [8:0] op_result;
  logic [2:0]        alg;
  logic [1:0]        pan;
`ifdef JT12_MIXER_DAC_EN
  logic              dac_en;
  logic signed [8:0] dac_data;
`endif
  logic signed [11:0] left;
  logic signed [11:0] right;
  logic               sample_valid;

  always #5 clk = ~clk;

  jt12_op_mixer #(.NUM_CH(6), .CH_W(9), .OUT_W(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en       (clk_en),
    .zero         (zero),
    .op_result    (op_result),
    .alg          (alg),
    .pan          (pan),
`ifdef JT12_MIXER_DAC_EN
    .dac_en       (dac_en),
    .dac_data     (dac_data),
`endif
    .left         (left),
    .right        (right),
    .sample_valid (sample_valid)
  );

  // ---------------------------------------------------------------------------
  // Vectors and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [24*9-1:0] ops;
    logic [17:0]     algs;
    logic [11:0]     pans;
    logic            dac;
    logic            use_zero;
    logic [11:0]     exp_l;
    logic [11:0]     exp_r;
  } vec_t;

  localparam int NUM_VEC = 10;

  vec_t        vecs [NUM_VEC];
  logic [23:0] exp_q [$];
  logic [23:0] mon_exp;
  logic [11:0] last_l = '0;
  logic [11:0] last_r = '0;
  int          n_checks = 0;
  int          n_fail   = 0;

  // ch0 gets its own four operator values; every other slot gets oth.
  function automatic vec_t mk(input logic [2:0] alg0, input logic [2:0] alg_o,
                              input logic [1:0] pan0, input logic [1:0] pan_o,
                              input int s1, input int s3, input int s2, input int s4,
                              input int oth, input int el, input int er,
                              input logic uz);
    vec_t v;
    int   val;
    v = '0;
    for (int s = 0; s < 24; s++) begin
      if ((s % 6) != 0) begin
        val = oth;
      end else begin
        case (s / 6)
          0:       val = s1;
          1:       val = s3;
          2:       val = s2;
          default: val = s4;
        endcase
      end
      v.ops[s*9 +: 9] = 9'(val);
    end
    for (int c = 0; c < 6; c++) begin
      v.algs[c*3 +: 3] = (c == 0) ? alg0 : alg_o;
      v.pans[c*2 +: 2] = (c == 0) ? pan0 : pan_o;
    end
    v.dac      = 1'b0;
    v.use_zero = uz;
    v.exp_l    = 12'(el);
    v.exp_r    = 12'(er);
    return v;
  endfunction

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, $signed(got), $signed(req));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_slot(input logic z, input logic [8:0] op, input logic [2:0] a,
                            input logic [1:0] p, input logic d);
    // Random idle gap with garbage on every input; nothing may change.
    if ($urandom_range(0, 3) == 0) begin
      clk_en    = 1'b0;
      zero      = 1'($urandom_range(0, 1));
      op_result = 9'($urandom_range(0, 511));
      alg       = 3'($urandom_range(0, 7));
      pan       = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1;
    end
    clk_en    = 1'b1;
    zero      = z;
    op_result = op;
    alg       = a;
    pan       = p;
`ifdef JT12_MIXER_DAC_EN
    dac_en    = d;
`else
    if (d) begin
      $display("note: DAC vector run as plain FM frame");
    end
`endif
    @(posedge clk);
    #1;
    clk_en = 1'b0;
    zero   = 1'b0;
  endtask

  task automatic drive_frame(input vec_t v, input logic uz, input logic push, input int n);
    if (push) begin
      exp_q.push_back({v.exp_l, v.exp_r});
      last_l = v.exp_l;
      last_r = v.exp_r;
    end
    for (int s = 0; s < n; s++) begin
      drive_slot((s == 0) && uz, v.ops[s*9 +: 9], v.algs[(s%6)*3 +: 3],
                 v.pans[(s%6)*2 +: 2], v.dac);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compare on the falling edge, away from the active edge.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (sample_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got strobe with left=%0d right=%0d, required none",
                 left, right);
      end else begin
        mon_exp = exp_q.pop_front();
        check("left", left, mon_exp[23:12]);
        check("right", right, mon_exp[11:0]);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  int dac_exp;

  initial begin
    rst_n     = 1'b0;
    clk_en    = 1'b0;
    zero      = 1'b0;
    op_result = '0;
    alg       = '0;
    pan       = '0;
`ifdef JT12_MIXER_DAC_EN
    dac_en    = 1'b0;
    dac_data  = -9'sd100;
    dac_exp   = -100;
`else
    dac_exp   = 20;
`endif

    //          alg0 algO pan0 panO   s1    s3    s2    s4   oth    L     R   zero
    vecs[0] = mk(7,  0,   3,   3,     10,   10,   10,   10,  0,     40,   40,  1);
    vecs[1] = mk(0,  0,   3,   3,    100,  100,  100,    5,  0,      5,    5,  1);
    vecs[2] = mk(4,  0,   3,   3,    100,  100,  100,    5,  0,    105,  105,  0);
    vecs[3] = mk(7,  0,   3,   3,    200,  200,  200,  200,  0,    255,  255,  1);
    vecs[4] = mk(7,  0,   3,   3,   -256, -256, -256, -256,  0,   -256, -256,  1);
    vecs[5] = mk(7,  7,   2,   2,    200,  200,  200,  200,  200, 1530,    0,  1);
    vecs[6] = mk(5,  7,   1,   0,     50,   20,   30,    1,  7,      0,   51,  1);
    vecs[7] = mk(0,  0,   3,   3,     -3,   -3,   -3,   -3, -3,    -18,  -18,  1);
    vecs[8] = mk(0,  0,   0,   0,      0,    0,    0,    0,  0, dac_exp, dac_exp, 1);
    vecs[8].ops[23*9 +: 9] = 9'd20;
    vecs[8].pans[10 +: 2]  = 2'b11;
    vecs[8].dac            = 1'b1;
    vecs[9] = mk(6,  3,   3,   1,    100,  -50,  -60, -200,  1,   -256, -251,  1);

    repeat (3) @(posedge clk);
    #1;
    check("reset_left", left, 12'd0);
    check("reset_right", right, 12'd0);
    check("reset_valid", 12'(sample_valid), 12'd0);
    rst_n = 1'b1;

    // Never synchronised: accumulates but must not publish.
    drive_frame(vecs[0], 1'b0, 1'b0, 24);
    repeat (2) @(posedge clk);
    #1;
    check("unsynced_left", left, 12'd0);
    check("unsynced_right", right, 12'd0);

    for (int i = 0; i < NUM_VEC; i++) begin
      drive_frame(vecs[i], vecs[i].use_zero, 1'b1, 24);
    end

    // Resync at slot 10: broken frame produces nothing, outputs hold.
    drive_frame(vecs[3], 1'b1, 1'b0, 10);
    check("hold_left", left, last_l);
    check("hold_right", right, last_r);
    drive_frame(vecs[0], 1'b1, 1'b1, 24);

    // Asynchronous reset in the middle of a frame.
    drive_frame(vecs[5], 1'b1, 1'b0, 12);
    rst_n = 1'b0;
    #2;
    check("midreset_left", left, 12'd0);
    check("midreset_right", right, 12'd0);
    check("midreset_valid", 12'(sample_valid), 12'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_frame(vecs[1], 1'b0, 1'b0, 24);
    repeat (2) @(posedge clk);
    #1;
    check("post_reset_left", left, 12'd0);
    check("post_reset_right", right, 12'd0);
    drive_frame(vecs[7], 1'b1, 1'b1, 24);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d samples outstanding, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
